// File: rtl/mat_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mat_pkg : shared matrix cell/frame types for the matrix datapath.  rev 1.0
// ----------------------------------------------------------------------------
package mat_pkg;
  localparam int CELL_W  = 8;
  localparam int N_CELLS = 9;

  typedef logic [CELL_W-1:0] cell_t;
  typedef cell_t mat_t [N_CELLS];

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } frame_state_t;
endpackage
`default_nettype wire

// File: rtl/uart_tx_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_core : single-byte 8N1 transmitter with back-to-back chaining.  rev 1.0
// ----------------------------------------------------------------------------
module uart_tx_core #(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);
  import mat_pkg::*;

  localparam int                 c_cnt_w    = $clog2(CLKS_PER_BIT);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_pre  = c_cnt_w'(CLKS_PER_BIT - 2);

  frame_state_t       r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [2:0]         r_bit;
  logic [7:0]         r_shift;
  logic               r_tx;
  logic               r_busy;
  logic               r_done;
  logic               w_bit_end;

  assign w_bit_end = (r_cnt == c_cnt_last);

  // o_done marks the final cycle of the stop bit, so the sequencer can chain
  // the next byte on the same edge without an idle gap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == ST_STOP) && (r_cnt == c_cnt_pre);
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_shift <= i_data;
            r_cnt   <= '0;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= ST_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (i_start) begin
              r_shift <= i_data;
              r_tx    <= 1'b0;
              r_state <= ST_START;
            end else begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_tx   = r_tx;
  assign o_busy = r_busy;
  assign o_done = r_done;
endmodule
`default_nettype wire

// File: rtl/mat_uart_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mat_uart_tx : sends a 3x3 matrix as row-major 8N1 bytes; optional XOR
//               checksum byte with MAT_UART_TX_CHECKSUM_EN.  rev 1.0
// ----------------------------------------------------------------------------
module mat_uart_tx #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int N_CELLS      = 9
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [7:0] i_mat [N_CELLS],
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done,
  output logic [3:0] o_idx
);
  import mat_pkg::*;

`ifdef MAT_UART_TX_CHECKSUM_EN
  localparam int c_last_idx = N_CELLS;
`else
  localparam int c_last_idx = N_CELLS - 1;
`endif

  cell_t      r_snap [N_CELLS];
  logic       r_busy;
  logic       r_done;
  logic [3:0] r_idx;

  logic       w_accept;
  logic       w_more;
  logic       w_core_start;
  logic       w_core_busy;
  logic       w_core_last;
  logic [3:0] w_next_idx;
  cell_t      w_next_byte;
  cell_t      w_core_data;

  // r_done gates the load so a strobe in the done cycle is not taken.
  assign w_accept     = i_load && !r_busy && !r_done && !w_core_busy;
  assign w_more       = w_core_last && (r_idx != 4'(c_last_idx));
  assign w_next_idx   = r_idx + 4'd1;
  assign w_core_start = w_accept || w_more;
  assign w_core_data  = w_accept ? i_mat[0] : w_next_byte;

`ifdef MAT_UART_TX_CHECKSUM_EN
  cell_t r_csum;
  cell_t w_mat_xor;

  always_comb begin
    w_mat_xor = '0;
    for (int i = 0; i < N_CELLS; i++) begin
      w_mat_xor = w_mat_xor ^ i_mat[i];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_csum <= '0;
    end else if (w_accept) begin
      r_csum <= w_mat_xor;
    end
  end

  assign w_next_byte = ({28'd0, w_next_idx} < N_CELLS) ? r_snap[w_next_idx] : r_csum;
`else
  assign w_next_byte = r_snap[w_next_idx];
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < N_CELLS; i++) begin
        r_snap[i] <= '0;
      end
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_idx  <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        for (int i = 0; i < N_CELLS; i++) begin
          r_snap[i] <= i_mat[i];
        end
        r_busy <= 1'b1;
        r_idx  <= '0;
      end else if (w_core_last) begin
        if (w_more) begin
          r_idx <= w_next_idx;
        end else begin
          r_idx  <= '0;
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_start(w_core_start),
    .i_data (w_core_data),
    .o_tx   (o_tx),
    .o_busy (w_core_busy),
    .o_done (w_core_last)
  );

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_idx  = r_idx;
endmodule
`default_nettype wire

// File: doc/mat_uart_tx.md
# mat_uart_tx

Serialises a 3x3 matrix of 8-bit cells onto the UART TX line as nine 8N1 bytes in row-major order, with its own baud timing. It sits between the matrix multiplier result and the TX pin. It is the send-side counterpart of the byte receiver and matrix buffer pair: whatever that pair reassembles into a matrix, this block emits in the same byte order.

## Interface
Parameters:
- CLKS_PER_BIT, 1250 — i_clk cycles per UART bit (12 MHz / 9600 baud); legal range is 2 and up.
- N_CELLS, 9 — matrix cells per frame, sent row-major, cell 0 first.

Ports:
- i_clk  in  1  — system clock; the only clock.
- i_rst  in  1  — asynchronous, active-high reset.
- i_load  in  1  — start strobe; sampled only in IDLE.
- i_mat  in  N_CELLS x 8 (unpacked)  — matrix to send; captured on an accepted i_load.
- o_tx  out  1  — UART line; idles high.
- o_busy  out  1  — high from the cycle after an accepted load until the end of the last stop bit.
- o_done  out  1  — one-cycle pulse when the frame completes.
- o_idx  out  4  — index of the byte currently on the line; 0 when idle.

## Operation
- Reset values:
  - o_tx = 1, o_busy = 0, o_done = 0, o_idx = 0.
  - State is IDLE and the snapshot registers are cleared.
- States: IDLE -> START -> DATA -> STOP -> (NEXT byte: START | done: IDLE).
  - IDLE: o_tx = 1. On i_load = 1, copy i_mat into the snapshot, set idx = 0 and go to START. i_mat is not sampled again during the frame.
  - START: o_tx = 0 for CLKS_PER_BIT cycles.
  - DATA: send 8 bits LSB first, CLKS_PER_BIT cycles each. A 3-bit counter tracks the bit position.
  - STOP: o_tx = 1 for CLKS_PER_BIT cycles.
    - If idx < last, increment idx and go to START with no extra idle bit between bytes.
    - Otherwise pulse o_done and go to IDLE.
- The baud counter reloads at every state entry, so there is no accumulated drift.
- i_load while busy is ignored and not queued. i_load held high in IDLE starts a new frame on the first IDLE cycle after o_done.
- i_load in the same cycle that o_done pulses is ignored, because the block is not yet in IDLE.
- Reset mid-frame aborts the frame:
  - o_tx returns high immediately (asynchronously), and o_done does not pulse.
  - The receiver may see a truncated byte; that is acceptable.

## Timing
- Load at edge k (i_load high): o_busy = 1 and o_tx = 0 (start bit) from edge k+1.
- One byte occupies 10*CLKS_PER_BIT cycles.
- A frame of B bytes occupies B*10*CLKS_PER_BIT cycles (B = N_CELLS, or N_CELLS+1 with the checksum). o_busy is high for exactly that many cycles.
- o_done is high in the first cycle after the last stop bit completes, the same cycle o_busy falls.
- o_tx is driven directly from a register, so there is no combinational path from any input to it.
- o_idx changes on the first cycle of each start bit.

## Configuration
- MAT_UART_TX_CHECKSUM_EN defined:
  - After the last cell, send one extra byte equal to the XOR of all N_CELLS snapshot bytes.
  - The checksum is computed at load time and stored alongside the snapshot.
  - o_idx reaches N_CELLS for the checksum byte.
- Not defined: exactly N_CELLS bytes are sent, and no checksum logic is synthesised.

## Structure
- Shared package mat_pkg holds:
  - constants CELL_W = 8 and N_CELLS = 9;
  - typedefs cell_t and mat_t (an N_CELLS array of cell_t);
  - the frame-state enum.
- The receive-side buffer and the multiplier use the same package.
- Sub-module uart_tx_core handles a single byte:
  - ports: i_clk, i_rst, i_start, i_data[7:0], o_tx, o_busy, o_done;
  - it contains the baud counter, shift register and start/stop framing.
  - mat_uart_tx sequences bytes into it and adds the checksum.

## Test plan
Simulate with CLKS_PER_BIT = 4.
- Reset then idle: hold 100 cycles -> o_tx = 1, o_busy = 0, o_done = 0, o_idx = 0 throughout.
- Sequential frame: load i_mat = {1,2,...,9} -> a line-decoder monitor sees bytes 0x01..0x09 in order.
  - o_busy is high for exactly 360 cycles.
  - o_done pulses once, on cycle 361 after the load.
- Pattern and bit order: load {0x55,0xAA,0x00,0xFF,0x80,0x01,0x7E,0x81,0x3C} -> each start bit is low for 4 cycles, data goes LSB first, each stop bit is high for 4 cycles, and the decoded bytes match.
- Load while busy: pulse i_load with different data mid-frame -> it is ignored, the original bytes are sent, and no second frame follows.
- Reset mid-frame: assert i_rst during byte 4 DATA -> o_tx = 1 in the same cycle, o_busy = 0, no o_done pulse. A new load afterwards sends the full frame correctly.
- With MAT_UART_TX_CHECKSUM_EN: load {1..9} -> a tenth byte 0x01 (the XOR of 1..9) is sent, o_busy lasts 400 cycles, and o_idx reaches 9.
